mem_access: RTL and testbench
=============================

# mem_access

Memory-stage access engine of the five-stage RISC-V core, sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the load/store request fields produced by EX/MEM, performs byte-serial little-endian accesses to an 8-bit synchronous RAM, and holds the pipeline with a stall request while the access is in flight. It delivers sign- or zero-extended load data, or passes ALU results through, to write-back.

## Interface
- ADDR_WIDTH, 32, RAM address width; the effective address is regw_data_i[ADDR_WIDTH-1:0].
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high.
- write_i  in  1  register write-back enable.
- regw_addr_i  in  5  destination register.
- regw_data_i  in  32  ALU result; the byte address for a load or store.
- load_i  in  1  load request.
- store_i  in  1  store request.
- mem_write_data_i  in  32  store data.
- mem_length_i  in  3  access size in bytes: 1, 2 or 4.
- mem_signed_i  in  1  load sign-extension select.
- ram_addr_o  out  ADDR_WIDTH  byte address.
- ram_data_o  out  8  store byte.
- ram_wr_o  out  1  write strobe.
- ram_data_i  in  8  read byte, valid one cycle after its address is presented.
- stall_req_o  out  1  holds EX/MEM and the stages before it.
- misalign_o  out  1  misaligned-access flag (see Configuration).
- write_o, regw_addr_o (5), regw_data_o (32)  out  write-back fields to MEM/WB.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - RD: load bytes in flight.
  - WR: store bytes in flight.
  - DONE: access complete.
- Byte counter cnt, 3 bits.
- Assembly register buf, 32 bits.
- N = mem_length_i. Any value other than 1, 2 or 4 is treated as 4.
- Inputs are stable while stall_req_o=1, because EX/MEM holds.
- Non-memory op in IDLE (load_i=0, store_i=0):
  - Zero-latency combinational pass-through of write_i, regw_addr_i and regw_data_i.
  - stall_req_o=0; ram_wr_o=0.
- Simultaneous load_i and store_i: the access is treated as a load.
- Byte k uses address addr+k, wrapping modulo 2^ADDR_WIDTH. It carries bits [8k+7:8k] of the data (little-endian).
- Load:
  - IDLE presents addr+0, sets cnt=1, and moves to RD.
  - In RD with cnt=k: buf byte k-1 is loaded from ram_data_i.
    - If k<N: present addr+k, then cnt=k+1.
    - If k=N: move to DONE.
- Store:
  - IDLE presents byte 0 with ram_wr_o=1, sets cnt=1, and moves to WR, or to DONE if N=1.
  - In WR: present byte cnt with ram_wr_o=1, then cnt+1. Move to DONE once byte N-1 has been issued.
- stall_req_o=1 in IDLE whenever an access starts, and throughout RD and WR. It is 0 in DONE.
- DONE:
  - regw_data_o is the extended buf for a load, and regw_data_i for a store.
  - write_o=write_i; regw_addr_o=regw_addr_i.
  - Next state is IDLE unconditionally, so the still-present request is not restarted.
- Extension of load data:
  - N=1: bit 7 if mem_signed_i, else zero.
  - N=2: bit 15 if mem_signed_i, else zero.
  - N=4: none.
- ram_addr_o=0 when no address is being presented. ram_data_o=0 when not writing.

## Timing
- Load: N+1 stall cycles; the result is valid in DONE, N+1 cycles after the request appears.
- Store: N stall cycles, then DONE.
- Back-to-back accesses: a new request starts in the IDLE cycle that follows DONE. There is no idle bubble beyond DONE.
- Reset asserted:
  - State is forced to IDLE and cnt=0, buf=0 immediately.
  - While reset is high, all outputs are 0.
- Reset mid-operation:
  - The access is abandoned.
  - Bytes of a store already written stay written; there is no rollback.
  - ram_wr_o drops asynchronously.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A misaligned access is one with N=2 and addr[0]=1, or N=4 and addr[1:0]≠0.
  - Such an access generates no RAM traffic and no stall.
  - The block goes directly from IDLE to DONE the next cycle with misalign_o=1 for that DONE cycle.
  - write_o=0 in that DONE cycle.
- MEM_ALIGN_CHECK_EN undefined:
  - misalign_o is tied to 0.
  - Misaligned accesses proceed byte-serially like any other.

## Test plan
- Signed byte load, addr 0x100, RAM[0x100]=0x80 -> stall_req_o high 2 cycles, then regw_data_o=0xFFFFFF80 with write_o=1.
- Unsigned halfword load, addr 0x200, RAM bytes 0x34,0x12 -> ram_addr_o sequence 0x200,0x201; stall 3 cycles; regw_data_o=0x00001234.
- Word store, data 0xDEADBEEF, addr 0x300 -> ram_wr_o high 4 consecutive cycles, writing bytes EF,BE,AD,DE to 0x300–0x303; stall 4 cycles; then write_o=0.
- ALU op with write_i=1, regw_data_i=0x55 -> same-cycle pass-through, stall_req_o=0, no ram_wr_o.
- Reset asserted during the 3rd byte of a word store -> all outputs 0 immediately; bytes 0–1 remain in RAM; the next request starts cleanly from IDLE.
- With MEM_ALIGN_CHECK_EN, word load at 0x102 -> no RAM access; misalign_o=1 for one cycle; stall_req_o stays 0.

Source files
------------

// File: rtl/mem_access_if.sv
// Bundle between the memory-stage access engine, the EX/MEM + MEM/WB pipeline fields
// and the byte-wide synchronous RAM.
interface mem_access_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  write_i;
  logic [4:0]            regw_addr_i;
  logic [31:0]           regw_data_i;
  logic                  load_i;
  logic                  store_i;
  logic [31:0]           mem_write_data_i;
  logic [2:0]            mem_length_i;
  logic                  mem_signed_i;

  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [7:0]            ram_data_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_data_i;

  logic                  stall_req_o;
  logic                  misalign_o;
  logic                  write_o;
  logic [4:0]            regw_addr_o;
  logic [31:0]           regw_data_o;

  modport slave (
    input  write_i, regw_addr_i, regw_data_i, load_i, store_i, mem_write_data_i,
    input  mem_length_i, mem_signed_i, ram_data_i,
    output ram_addr_o, ram_data_o, ram_wr_o, stall_req_o, misalign_o,
    output write_o, regw_addr_o, regw_data_o
  );

  modport master (
    output write_i, regw_addr_i, regw_data_i, load_i, store_i, mem_write_data_i,
    output mem_length_i, mem_signed_i, ram_data_i,
    input  ram_addr_o, ram_data_o, ram_wr_o, stall_req_o, misalign_o,
    input  write_o, regw_addr_o, regw_data_o
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage access engine: byte-serial little-endian loads/stores to an 8-bit sync RAM.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  mem_access_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        is_load_q, is_load_d;
  logic        misalign_q, misalign_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [2:0]            n;
  logic                  is_access;
  logic                  misalign_det;
  logic [31:0]           wdata_sh;
  logic [1:0]            rd_idx;
  logic [31:0]           load_ext;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_data;
  logic                  ram_wr;
  logic                  stall;
  logic                  misalign;
  logic                  write;
  logic [4:0]            regw_addr;
  logic [31:0]           regw_data;

  assign addr      = bus.regw_data_i[ADDR_WIDTH-1:0];
  assign byte_addr = addr + ADDR_WIDTH'(cnt_q);
  assign is_access = bus.load_i | bus.store_i;
  assign n         = (bus.mem_length_i == 3'd1) ? 3'd1 :
                     (bus.mem_length_i == 3'd2) ? 3'd2 : 3'd4;
  assign wdata_sh  = bus.mem_write_data_i >> {cnt_q, 3'b000};
  assign rd_idx    = 2'(cnt_q - 3'd1);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_det = ((n == 3'd2) && addr[0]) || ((n == 3'd4) && (addr[1:0] != 2'b00));
`else
  assign misalign_det = 1'b0;
`endif

  always_comb begin
    unique case (n)
      3'd1:    load_ext = {{24{bus.mem_signed_i & buf_q[7]}}, buf_q[7:0]};
      3'd2:    load_ext = {{16{bus.mem_signed_i & buf_q[15]}}, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    is_load_d  = is_load_q;
    misalign_d = misalign_q;
    ram_addr   = '0;
    ram_data   = 8'h00;
    ram_wr     = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    write      = bus.write_i;
    regw_addr  = bus.regw_addr_i;
    regw_data  = bus.regw_data_i;

    unique case (state_q)
      StIdle: begin
        cnt_d      = 3'd0;
        misalign_d = 1'b0;
        if (is_access) begin
          // A simultaneous load and store is handled as a load.
          is_load_d = bus.load_i;
          write     = 1'b0;
          if (misalign_det) begin
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
            stall    = 1'b1;
            cnt_d    = 3'd1;
            ram_addr = addr;
            if (bus.load_i) begin
              state_d = StRd;
            end else begin
              ram_wr   = 1'b1;
              ram_data = bus.mem_write_data_i[7:0];
              state_d  = (n == 3'd1) ? StDone : StWr;
            end
          end
        end
      end
      StRd: begin
        stall = 1'b1;
        write = 1'b0;
        buf_d[{rd_idx, 3'b000} +: 8] = bus.ram_data_i;
        if (cnt_q < n) begin
          ram_addr = byte_addr;
          cnt_d    = cnt_q + 3'd1;
        end else begin
          state_d = StDone;
        end
      end
      StWr: begin
        stall    = 1'b1;
        write    = 1'b0;
        ram_wr   = 1'b1;
        ram_addr = byte_addr;
        ram_data = wdata_sh[7:0];
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == n - 3'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        write    = bus.write_i & ~misalign_q;
        misalign = misalign_q;
        if (is_load_q && !misalign_q) begin
          regw_data = load_ext;
        end
        // The request is still on the inputs here; returning to idle must not restart it.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      ram_addr  = '0;
      ram_data  = 8'h00;
      ram_wr    = 1'b0;
      stall     = 1'b0;
      misalign  = 1'b0;
      write     = 1'b0;
      regw_addr = 5'd0;
      regw_data = 32'h0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      buf_q      <= 32'h0;
      is_load_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      is_load_q  <= is_load_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_data_o  = ram_data;
  assign bus.ram_wr_o    = ram_wr;
  assign bus.stall_req_o = stall;
  assign bus.write_o     = write;
  assign bus.regw_addr_o = regw_addr;
  assign bus.regw_data_o = regw_data;
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.misalign_o  = misalign;
`else
  assign bus.misalign_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a 4 KiB byte RAM model behind the engine.
module tb_mem_access;
  localparam int unsigned AW = 32;

  logic clock = 1'b0;
  logic reset;

  mem_access_if #(.ADDR_WIDTH(AW)) bus ();

  mem_access #(.ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0]  ram [0:4095];
  logic [7:0]  rd_q;
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = 12'h0;
  logic [7:0]  pre_data = 8'h0;

  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.ram_wr_o) ram[bus.ram_addr_o[11:0]] <= bus.ram_data_o;
    rd_q <= ram[bus.ram_addr_o[11:0]];
  end
  assign bus.ram_data_i = rd_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.write_i          = 1'b0;
    bus.regw_addr_i      = 5'd0;
    bus.regw_data_i      = 32'h0;
    bus.load_i           = 1'b0;
    bus.store_i          = 1'b0;
    bus.mem_write_data_i = 32'h0;
    bus.mem_length_i     = 3'd0;
    bus.mem_signed_i     = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] len,
                         input logic sgn, input logic [31:0] exp, input logic also_store);
    int n;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    bus.load_i       = 1'b1;
    bus.store_i      = also_store;
    bus.regw_data_i  = addr;
    bus.mem_length_i = len;
    bus.mem_signed_i = sgn;
    bus.write_i      = 1'b1;
    bus.regw_addr_i  = 5'd9;
    for (int k = 0; k <= n; k++) begin
      @(negedge clock);
      check({tag, " stall"}, 32'(bus.stall_req_o), 32'd1);
      check({tag, " addr"}, bus.ram_addr_o, (k < n) ? addr + 32'(k) : 32'h0);
      check({tag, " wr"}, 32'(bus.ram_wr_o), 32'd0);
      step();
    end
    @(negedge clock);
    check({tag, " done stall"}, 32'(bus.stall_req_o), 32'd0);
    check({tag, " data"}, bus.regw_data_o, exp);
    check({tag, " write"}, 32'(bus.write_o), 32'd1);
    check({tag, " rd"}, 32'(bus.regw_addr_o), 32'd9);
    check({tag, " misalign"}, 32'(bus.misalign_o), 32'd0);
    step();
    idle_inputs();
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] len,
                          input logic [31:0] data);
    int n;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    bus.store_i          = 1'b1;
    bus.regw_data_i      = addr;
    bus.mem_length_i     = len;
    bus.mem_write_data_i = data;
    bus.write_i          = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check({tag, " stall"}, 32'(bus.stall_req_o), 32'd1);
      check({tag, " wr"}, 32'(bus.ram_wr_o), 32'd1);
      check({tag, " addr"}, bus.ram_addr_o, addr + 32'(k));
      check({tag, " byte"}, 32'(bus.ram_data_o), (data >> (8 * k)) & 32'hFF);
      step();
    end
    @(negedge clock);
    check({tag, " done stall"}, 32'(bus.stall_req_o), 32'd0);
    check({tag, " done wr"}, 32'(bus.ram_wr_o), 32'd0);
    check({tag, " write"}, 32'(bus.write_o), 32'd0);
    step();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.write_i     = 1'b1;
    bus.regw_addr_i = 5'd3;
    bus.regw_data_i = 32'h55;
    bus.load_i      = 1'b1;

    @(negedge clock);
    check("rst write", 32'(bus.write_o), 32'd0);
    check("rst data", bus.regw_data_o, 32'h0);
    check("rst stall", 32'(bus.stall_req_o), 32'd0);
    check("rst addr", bus.ram_addr_o, 32'h0);
    step();

    preload(12'h100, 8'h80);
    preload(12'h200, 8'h34);
    preload(12'h201, 8'h12);
    preload(12'h202, 8'hAB);
    for (int i = 0; i < 4; i++) begin
      preload(12'h300 + 12'(i), 8'h00);
      preload(12'h400 + 12'(i), 8'h00);
    end
    idle_inputs();
    reset = 1'b0;
    step();

    // ALU pass-through
    bus.write_i     = 1'b1;
    bus.regw_addr_i = 5'd7;
    bus.regw_data_i = 32'h55;
    #1;
    check("alu write", 32'(bus.write_o), 32'd1);
    check("alu data", bus.regw_data_o, 32'h55);
    check("alu rd", 32'(bus.regw_addr_o), 32'd7);
    check("alu stall", 32'(bus.stall_req_o), 32'd0);
    check("alu wr", 32'(bus.ram_wr_o), 32'd0);
    step();
    idle_inputs();

    do_load("lb", 32'h100, 3'd1, 1'b1, 32'hFFFFFF80, 1'b0);
    do_load("lbu", 32'h100, 3'd1, 1'b0, 32'h00000080, 1'b0);
    do_load("lhu", 32'h200, 3'd2, 1'b0, 32'h00001234, 1'b0);
    do_load("ld+st", 32'h200, 3'd2, 1'b0, 32'h00001234, 1'b1);
    do_store("sw", 32'h300, 3'd4, 32'hDEADBEEF);
    do_load("lw", 32'h300, 3'd4, 1'b0, 32'hDEADBEEF, 1'b0);
    do_load("len3", 32'h300, 3'd3, 1'b0, 32'hDEADBEEF, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    bus.load_i       = 1'b1;
    bus.regw_data_i  = 32'h102;
    bus.mem_length_i = 3'd4;
    bus.write_i      = 1'b1;
    @(negedge clock);
    check("mis stall", 32'(bus.stall_req_o), 32'd0);
    check("mis addr", bus.ram_addr_o, 32'h0);
    check("mis flag0", 32'(bus.misalign_o), 32'd0);
    step();
    @(negedge clock);
    check("mis flag", 32'(bus.misalign_o), 32'd1);
    check("mis write", 32'(bus.write_o), 32'd0);
    check("mis stall2", 32'(bus.stall_req_o), 32'd0);
    step();
    idle_inputs();
    @(negedge clock);
    check("mis flag off", 32'(bus.misalign_o), 32'd0);
    step();
`else
    do_load("lh mis", 32'h201, 3'd2, 1'b1, 32'hFFFFAB12, 1'b0);
`endif

    // Reset during the third byte of a word store
    bus.store_i          = 1'b1;
    bus.regw_data_i      = 32'h400;
    bus.mem_length_i     = 3'd4;
    bus.mem_write_data_i = 32'hCAFEF00D;
    step();
    step();
    check("rs b2 wr", 32'(bus.ram_wr_o), 32'd1);
    check("rs b2 addr", bus.ram_addr_o, 32'h402);
    #1;
    reset = 1'b1;
    #1;
    check("rs wr", 32'(bus.ram_wr_o), 32'd0);
    check("rs stall", 32'(bus.stall_req_o), 32'd0);
    check("rs addr", bus.ram_addr_o, 32'h0);
    check("rs byte", 32'(bus.ram_data_o), 32'h0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    check("rs ram0", 32'(ram[12'h400]), 32'h0D);
    check("rs ram1", 32'(ram[12'h401]), 32'hF0);
    check("rs ram2", 32'(ram[12'h402]), 32'h00);
    do_load("after rst", 32'h400, 3'd2, 1'b0, 32'h0000F00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
